// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP instruction,
// the FSM state encodings and the default reset PC.
package stage_if_pkg;

    localparam logic [31:0] NOP                = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h80000000;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HALT    = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched {pc, instruction, fault} bundle
// that arrived while decode was stalled.
module if_skid_buffer
    import stage_if_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        load_access_fault,
    input  logic        load_misaligned,
    output logic        buf_valid,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_instr,
    output logic        buf_access_fault,
    output logic        buf_misaligned
);

    // flush wins over load so a redirect never leaves a stale entry behind
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buf_valid        <= 1'b0;
            buf_pc           <= 32'h0;
            buf_instr        <= NOP;
            buf_access_fault <= 1'b0;
            buf_misaligned   <= 1'b0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid        <= 1'b1;
            buf_pc           <= load_pc;
            buf_instr        <= load_instr;
            buf_access_fault <= load_access_fault;
            buf_misaligned   <= load_misaligned;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: PC register, Wishbone-classic fetch FSM, redirect
// handling and the registered bundle handed to decode.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        e_inst_access_fault_o,
    output logic        e_inst_addr_misaligned_o
);

    if_state_t   state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pc_stale_reg;

    logic        valid_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_out_reg;
    logic        access_fault_reg;
    logic        misaligned_reg;

    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic        buf_access_fault;
    logic        buf_misaligned;

    logic        out_free;
    logic        req_fetch;
    logic        cyc;
    logic        fetch_ack;
    logic        fetch_err;
    logic        misalign_go;
    logic        new_event;
    logic        bus_pending;
    logic [31:0] new_instr;

    assign out_free  = !valid_reg || !stall_i;
    // a buffered entry blocks new requests, so ack and drain never coincide
    assign req_fetch = (state_reg == S_FETCH) && !buf_valid && (pc_reg[1:0] == 2'b00);
    assign cyc       = rst_i && (req_fetch || (state_reg == S_DISCARD));

    assign fetch_err   = req_fetch && iwbm_err_i;
    assign fetch_ack   = req_fetch && iwbm_ack_i && !iwbm_err_i;
    assign misalign_go = (state_reg == S_FETCH) && (pc_reg[1:0] != 2'b00)
                         && !buf_valid && out_free;
    assign new_event   = fetch_ack || fetch_err || misalign_go;
    assign new_instr   = fetch_ack ? iwbm_dat_i : NOP;
    assign bus_pending = cyc && !iwbm_ack_i && !iwbm_err_i;

    assign iwbm_cyc_o  = cyc;
    assign iwbm_stb_o  = cyc;
    assign iwbm_addr_o = (state_reg == S_DISCARD) ? pc_stale_reg : pc_reg;

    assign instruction_o            = instr_reg;
    assign pc_o                     = pc_out_reg;
    assign valid_o                  = valid_reg;
    assign e_inst_access_fault_o    = access_fault_reg;
    assign e_inst_addr_misaligned_o = misaligned_reg;

    if_skid_buffer u_skid (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .load              (!redirect_en_i && (fetch_ack || fetch_err) && !out_free),
        .drain             (!redirect_en_i && buf_valid && out_free),
        .flush             (redirect_en_i),
        .load_pc           (pc_reg),
        .load_instr        (new_instr),
        .load_access_fault (fetch_err),
        .load_misaligned   (1'b0),
        .buf_valid         (buf_valid),
        .buf_pc            (buf_pc),
        .buf_instr         (buf_instr),
        .buf_access_fault  (buf_access_fault),
        .buf_misaligned    (buf_misaligned)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg        <= S_FETCH;
            pc_reg           <= RESET_ADDR;
            pc_stale_reg     <= 32'h0;
            valid_reg        <= 1'b0;
            instr_reg        <= NOP;
            pc_out_reg       <= 32'h0;
            access_fault_reg <= 1'b0;
            misaligned_reg   <= 1'b0;
        end else if (redirect_en_i) begin
            pc_reg           <= redirect_pc_i;
            valid_reg        <= 1'b0;
            access_fault_reg <= 1'b0;
            misaligned_reg   <= 1'b0;
            // an unfinished transfer must still be completed on the bus
            if (bus_pending) begin
                state_reg <= S_DISCARD;
                if (state_reg == S_FETCH) begin
                    pc_stale_reg <= pc_reg;
                end
            end else begin
                state_reg <= S_FETCH;
            end
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (fetch_ack) begin
                        pc_reg <= pc_reg + 32'd4;
                    end else if (fetch_err || misalign_go) begin
                        state_reg <= S_HALT;
                    end
                end
                S_DISCARD: begin
                    if (iwbm_ack_i || iwbm_err_i) begin
                        state_reg <= S_FETCH;
                    end
                end
                default: begin
                end
            endcase

            if (out_free) begin
                if (buf_valid) begin
                    valid_reg        <= 1'b1;
                    pc_out_reg       <= buf_pc;
                    instr_reg        <= buf_instr;
                    access_fault_reg <= buf_access_fault;
                    misaligned_reg   <= buf_misaligned;
                end else if (new_event) begin
                    valid_reg        <= 1'b1;
                    pc_out_reg       <= pc_reg;
                    instr_reg        <= new_instr;
                    access_fault_reg <= fetch_err;
                    misaligned_reg   <= misalign_go;
                end else begin
                    valid_reg        <= 1'b0;
                    access_fault_reg <= 1'b0;
                    misaligned_reg   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: a combinational Wishbone slave returns
// addr ^ 32'hFFFF0000, and each step checks the bundle and bus outputs.
module tb_stage_if;

    logic        clk;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_en_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] iwbm_addr_o;
    logic        iwbm_cyc_o;
    logic        iwbm_stb_o;
    logic [31:0] iwbm_dat_i;
    logic        iwbm_ack_i;
    logic        iwbm_err_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        e_inst_access_fault_o;
    logic        e_inst_addr_misaligned_o;

    logic ack_en;
    logic err_en;
    int   checks;
    int   errors;

    stage_if dut (
        .clk_i                    (clk),
        .rst_i                    (rst_i),
        .stall_i                  (stall_i),
        .redirect_en_i            (redirect_en_i),
        .redirect_pc_i            (redirect_pc_i),
        .iwbm_addr_o              (iwbm_addr_o),
        .iwbm_cyc_o               (iwbm_cyc_o),
        .iwbm_stb_o               (iwbm_stb_o),
        .iwbm_dat_i               (iwbm_dat_i),
        .iwbm_ack_i               (iwbm_ack_i),
        .iwbm_err_i               (iwbm_err_i),
        .instruction_o            (instruction_o),
        .pc_o                     (pc_o),
        .valid_o                  (valid_o),
        .e_inst_access_fault_o    (e_inst_access_fault_o),
        .e_inst_addr_misaligned_o (e_inst_addr_misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero-wait slave when ack_en=1; wait states by holding ack_en low
    assign iwbm_ack_i = iwbm_cyc_o && iwbm_stb_o && ack_en;
    assign iwbm_err_i = iwbm_cyc_o && iwbm_stb_o && err_en;
    assign iwbm_dat_i = iwbm_addr_o ^ 32'hFFFF0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i = 1'b0;
        stall_i = 1'b0;
        redirect_en_i = 1'b0;
        redirect_pc_i = 32'h0;
        ack_en = 1'b0;
        err_en = 1'b0;

        step();
        step();
        $display("reset held");
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_instr", instruction_o, 32'h00000013);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_cyc", {31'h0, iwbm_cyc_o}, 32'h0);
        chk("rst_faults", {30'h0, e_inst_access_fault_o, e_inst_addr_misaligned_o}, 32'h0);

        rst_i = 1'b1;
        ack_en = 1'b1;
        #1;
        $display("reset released, zero-wait fetch addr=%h", iwbm_addr_o);
        chk("first_addr", iwbm_addr_o, 32'h80000000);
        chk("first_cyc", {31'h0, iwbm_stb_o}, 32'h1);

        step();
        $display("fetch pc_o=%h instr=%h valid=%b", pc_o, instruction_o, valid_o);
        chk("f0_valid", {31'h0, valid_o}, 32'h1);
        chk("f0_pc", pc_o, 32'h80000000);
        chk("f0_instr", instruction_o, 32'h7FFF0000);
        chk("f1_addr", iwbm_addr_o, 32'h80000004);

        step();
        $display("fetch pc_o=%h instr=%h", pc_o, instruction_o);
        chk("f1_pc", pc_o, 32'h80000004);
        chk("f1_instr", instruction_o, 32'h7FFF0004);
        chk("f2_addr", iwbm_addr_o, 32'h80000008);

        // stall for three edges; 0x80000008 lands in the skid buffer
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            $display("stall %0d pc_o=%h cyc=%b", i, pc_o, iwbm_cyc_o);
            chk("stall_pc_hold", pc_o, 32'h80000004);
            chk("stall_no_req", {31'h0, iwbm_cyc_o}, 32'h0);
        end
        stall_i = 1'b0;

        step();
        $display("drain pc_o=%h instr=%h next addr=%h", pc_o, instruction_o, iwbm_addr_o);
        chk("drain_pc", pc_o, 32'h80000008);
        chk("drain_instr", instruction_o, 32'h7FFF0008);
        chk("drain_valid", {31'h0, valid_o}, 32'h1);
        chk("post_drain_addr", iwbm_addr_o, 32'h8000000C);

        step();
        $display("fetch pc_o=%h", pc_o);
        chk("f3_pc", pc_o, 32'h8000000C);
        chk("f4_addr", iwbm_addr_o, 32'h80000010);

        // wait-state slave; redirect during the first wait cycle
        ack_en = 1'b0;
        step();
        $display("wait cycle 1 valid=%b cyc=%b", valid_o, iwbm_cyc_o);
        chk("wait_valid", {31'h0, valid_o}, 32'h0);
        chk("wait_cyc", {31'h0, iwbm_cyc_o}, 32'h1);
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h80000100;
        step();
        redirect_en_i = 1'b0;
        $display("discard addr=%h cyc=%b", iwbm_addr_o, iwbm_cyc_o);
        chk("discard_addr", iwbm_addr_o, 32'h80000010);
        chk("discard_cyc", {31'h0, iwbm_cyc_o}, 32'h1);
        chk("discard_valid", {31'h0, valid_o}, 32'h0);
        step();
        ack_en = 1'b1;
        step();
        $display("after discard addr=%h valid=%b", iwbm_addr_o, valid_o);
        chk("stale_dropped", {31'h0, valid_o}, 32'h0);
        chk("redir_addr", iwbm_addr_o, 32'h80000100);
        step();
        $display("fetch pc_o=%h instr=%h", pc_o, instruction_o);
        chk("redir_pc", pc_o, 32'h80000100);
        chk("redir_instr", instruction_o, 32'h7FFF0100);

        // redirect coincident with an ack for 0x80000104
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h80000300;
        step();
        redirect_en_i = 1'b0;
        $display("redirect+ack valid=%b addr=%h", valid_o, iwbm_addr_o);
        chk("ack_redir_valid", {31'h0, valid_o}, 32'h0);
        chk("ack_redir_addr", iwbm_addr_o, 32'h80000300);
        step();
        $display("fetch pc_o=%h instr=%h", pc_o, instruction_o);
        chk("ack_redir_pc", pc_o, 32'h80000300);
        chk("ack_redir_instr", instruction_o, 32'h7FFF0300);

        // misaligned target
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h80000102;
        step();
        redirect_en_i = 1'b0;
        $display("misaligned pc loaded cyc=%b", iwbm_cyc_o);
        chk("mis_no_req", {31'h0, iwbm_cyc_o}, 32'h0);
        step();
        $display("misaligned bundle pc_o=%h mis=%b", pc_o, e_inst_addr_misaligned_o);
        chk("mis_valid", {31'h0, valid_o}, 32'h1);
        chk("mis_pc", pc_o, 32'h80000102);
        chk("mis_flag", {31'h0, e_inst_addr_misaligned_o}, 32'h1);
        chk("mis_instr", instruction_o, 32'h00000013);
        chk("mis_no_access", {31'h0, e_inst_access_fault_o}, 32'h0);
        step();
        chk("halt_no_req", {31'h0, iwbm_cyc_o}, 32'h0);

        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h80000200;
        step();
        redirect_en_i = 1'b0;
        $display("halt exit addr=%h", iwbm_addr_o);
        chk("halt_exit_addr", iwbm_addr_o, 32'h80000200);
        chk("halt_exit_cyc", {31'h0, iwbm_cyc_o}, 32'h1);
        step();
        chk("resume_pc", pc_o, 32'h80000200);
        chk("resume_mis", {31'h0, e_inst_addr_misaligned_o}, 32'h0);

        // bus error at 0x80000010
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h80000010;
        step();
        redirect_en_i = 1'b0;
        ack_en = 1'b0;
        err_en = 1'b1;
        chk("err_addr", iwbm_addr_o, 32'h80000010);
        step();
        err_en = 1'b0;
        $display("err bundle pc_o=%h fault=%b", pc_o, e_inst_access_fault_o);
        chk("err_valid", {31'h0, valid_o}, 32'h1);
        chk("err_flag", {31'h0, e_inst_access_fault_o}, 32'h1);
        chk("err_pc", pc_o, 32'h80000010);
        chk("err_instr", instruction_o, 32'h00000013);
        chk("err_cyc", {31'h0, iwbm_cyc_o}, 32'h0);
        step();
        chk("err_halt_cyc", {31'h0, iwbm_cyc_o}, 32'h0);
        chk("err_flag_clear", {31'h0, e_inst_access_fault_o}, 32'h0);

        // reset in the middle of a pending transfer
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h80000400;
        step();
        redirect_en_i = 1'b0;
        chk("pre_rst_addr", iwbm_addr_o, 32'h80000400);
        chk("pre_rst_cyc", {31'h0, iwbm_cyc_o}, 32'h1);
        rst_i = 1'b0;
        #1;
        $display("reset asserted mid-transfer cyc=%b", iwbm_cyc_o);
        chk("rst_cyc_drop", {31'h0, iwbm_cyc_o}, 32'h0);
        ack_en = 1'b1;
        step();
        chk("rst2_valid", {31'h0, valid_o}, 32'h0);
        chk("rst2_pc", pc_o, 32'h0);
        chk("rst2_instr", instruction_o, 32'h00000013);
        rst_i = 1'b1;
        #1;
        chk("rst2_addr", iwbm_addr_o, 32'h80000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
